uart_cmd_host: RTL

Host-side command initiator for the UART register/ALU command protocol. It turns one parallel command request into the framed byte stream that the system controller consumes: register write, register read, ALU with operands, or ALU without operands. It then collects the response bytes returned over UART RX and reports them, or a timeout, as a single parallel result. It sits between a test or host agent and a byte-level UART TX/RX pair, clocked in the same domain as that pair.

---
 rtl/uart_cmd_host_if.sv | 47 ++++
 rtl/uart_cmd_host.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_host_if.sv
// ============================================================================
// uart_cmd_host_if : command, UART byte and response bundle for uart_cmd_host
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cmd_host_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int TIMEOUT_WIDTH = 16
);
  logic                       i_cmd_valid;
  logic                       o_cmd_ready;
  logic [1:0]                 i_cmd_type;
  logic [ADDR_WIDTH-1:0]      i_addr;
  logic [DATA_WIDTH-1:0]      i_wr_data;
  logic [DATA_WIDTH-1:0]      i_op_a;
  logic [DATA_WIDTH-1:0]      i_op_b;
  logic [ALU_FUN_WIDTH-1:0]   i_alu_fun;
  logic [TIMEOUT_WIDTH-1:0]   i_timeout_limit;
  logic [DATA_WIDTH-1:0]      o_tx_data;
  logic                       o_tx_valid;
  logic                       i_tx_ready;
  logic [DATA_WIDTH-1:0]      i_rx_data;
  logic                       i_rx_valid;
  logic [2*DATA_WIDTH-1:0]    o_rsp_data;
  logic                       o_rsp_valid;
  logic                       o_rsp_timeout;

  // slave: the command host itself; master: the agent / UART pair around it
  modport slave (
    input  i_cmd_valid, i_cmd_type, i_addr, i_wr_data, i_op_a, i_op_b,
           i_alu_fun, i_timeout_limit, i_tx_ready, i_rx_data, i_rx_valid,
    output o_cmd_ready, o_tx_data, o_tx_valid, o_rsp_data, o_rsp_valid,
           o_rsp_timeout
  );

  modport master (
    output i_cmd_valid, i_cmd_type, i_addr, i_wr_data, i_op_a, i_op_b,
           i_alu_fun, i_timeout_limit, i_tx_ready, i_rx_data, i_rx_valid,
    input  o_cmd_ready, o_tx_data, o_tx_valid, o_rsp_data, o_rsp_valid,
           o_rsp_timeout
  );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_host.sv
// ============================================================================
// uart_cmd_host : frames one command onto UART TX and collects the RX response
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_host #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  wire logic      i_CLK,
  input  wire logic      i_RST,
  uart_cmd_host_if.slave bus
);

  localparam logic [1:0] c_cmd_wr   = 2'b00;
  localparam logic [1:0] c_cmd_rd   = 2'b01;
  localparam logic [1:0] c_cmd_alu  = 2'b10;

  localparam logic [DATA_WIDTH-1:0] c_sof_wr   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] c_sof_rd   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] c_sof_alu  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] c_sof_alun = DATA_WIDTH'(8'hDD);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                    state_q,   state_d;
  logic [1:0]                type_q,    type_d;
  logic [ADDR_WIDTH-1:0]     addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]     op_a_q,    op_a_d;
  logic [DATA_WIDTH-1:0]     op_b_q,    op_b_d;
  logic [ALU_FUN_WIDTH-1:0]  fun_q,     fun_d;
  logic [1:0]                idx_q,     idx_d;
  logic [1:0]                cnt_q,     cnt_d;
  logic [TIMEOUT_WIDTH-1:0]  timer_q,   timer_d;
  logic [2*DATA_WIDTH-1:0]   rsp_q,     rsp_d;
  logic                      tout_q,    tout_d;

  logic [DATA_WIDTH-1:0]     addr_ext;
  logic [DATA_WIDTH-1:0]     fun_ext;
  logic [DATA_WIDTH-1:0]     frame_byte;
  logic [1:0]                frame_last;
  logic [1:0]                rsp_cnt;
  logic [TIMEOUT_WIDTH-1:0]  timer_inc;
  logic [1:0]                cnt_inc;

  assign addr_ext  = DATA_WIDTH'(addr_q);
  assign fun_ext   = DATA_WIDTH'(fun_q);
  assign timer_inc = timer_q + TIMEOUT_WIDTH'(1);
  assign cnt_inc   = cnt_q + 2'd1;

  // Frame contents, last byte index and expected response length per command
  always_comb begin
    frame_byte = '0;
    frame_last = 2'd0;
    rsp_cnt    = 2'd0;
    case (type_q)
      c_cmd_wr: begin
        frame_last = 2'd2;
        rsp_cnt    = 2'd0;
        case (idx_q)
          2'd0:    frame_byte = c_sof_wr;
          2'd1:    frame_byte = addr_ext;
          default: frame_byte = wr_data_q;
        endcase
      end
      c_cmd_rd: begin
        frame_last = 2'd1;
        rsp_cnt    = 2'd1;
        frame_byte = (idx_q == 2'd0) ? c_sof_rd : addr_ext;
      end
      c_cmd_alu: begin
        frame_last = 2'd3;
        rsp_cnt    = 2'd2;
        case (idx_q)
          2'd0:    frame_byte = c_sof_alu;
          2'd1:    frame_byte = op_a_q;
          2'd2:    frame_byte = op_b_q;
          default: frame_byte = fun_ext;
        endcase
      end
      default: begin
        frame_last = 2'd1;
        rsp_cnt    = 2'd2;
        frame_byte = (idx_q == 2'd0) ? c_sof_alun : fun_ext;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    fun_d     = fun_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    rsp_d     = rsp_q;
    tout_d    = tout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          type_d    = bus.i_cmd_type;
          addr_d    = bus.i_addr;
          wr_data_d = bus.i_wr_data;
          op_a_d    = bus.i_op_a;
          op_b_d    = bus.i_op_b;
          fun_d     = bus.i_alu_fun;
          idx_d     = 2'd0;
          rsp_d     = '0;
          tout_d    = 1'b0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.i_tx_ready) begin
          if (idx_q == frame_last) begin
            timer_d = '0;
            cnt_d   = 2'd0;
            state_d = (rsp_cnt == 2'd0) ? ST_DONE : ST_WAIT_RSP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_WAIT_RSP: begin
        // A byte in the same cycle as the limit takes priority over the timeout
        if (bus.i_rx_valid) begin
          rsp_d[cnt_q[0]*DATA_WIDTH +: DATA_WIDTH] = bus.i_rx_data;
          timer_d = '0;
          cnt_d   = cnt_inc;
          if (cnt_inc == rsp_cnt) begin
            state_d = ST_DONE;
          end
        end else begin
          timer_d = timer_inc;
          if ((bus.i_timeout_limit != '0) && (timer_inc == bus.i_timeout_limit)) begin
            tout_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q   <= ST_IDLE;
      type_q    <= 2'b00;
      addr_q    <= '0;
      wr_data_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      fun_q     <= '0;
      idx_q     <= 2'd0;
      cnt_q     <= 2'd0;
      timer_q   <= '0;
      rsp_q     <= '0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      fun_q     <= fun_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      rsp_q     <= rsp_d;
      tout_q    <= tout_d;
    end
  end

  assign bus.o_cmd_ready   = (state_q == ST_IDLE);
  assign bus.o_tx_valid    = (state_q == ST_SEND);
  assign bus.o_tx_data     = (state_q == ST_SEND) ? frame_byte : '0;
  assign bus.o_rsp_data    = rsp_q;
  assign bus.o_rsp_valid   = (state_q == ST_DONE);
  assign bus.o_rsp_timeout = (state_q == ST_DONE) && tout_q;

endmodule

`default_nettype wire
